// File: rtl/slot_config_sequencer_if.sv
// Runtime slot-update request channel plus the slotmaker configuration port.
// The sequencer is the slave: it accepts updates and drives the config write strobe.
interface slot_config_sequencer_if #(
  parameter int SLOT_W = 3,
  parameter int CARD_W = 8
);
  logic              upd_valid_i;
  logic [SLOT_W-1:0] upd_slot_i;
  logic [CARD_W-1:0] upd_card_i;
  logic              upd_ready_o;
  logic [SLOT_W-1:0] cfg_slot_o;
  logic              cfg_wr_o;
  logic [CARD_W-1:0] cfg_card_o;

  modport master (
    output upd_valid_i, upd_slot_i, upd_card_i,
    input  upd_ready_o, cfg_slot_o, cfg_wr_o, cfg_card_o
  );

  modport slave (
    input  upd_valid_i, upd_slot_i, upd_card_i,
    output upd_ready_o, cfg_slot_o, cfg_wr_o, cfg_card_o
  );
endinterface

// File: rtl/slot_config_sequencer.sv
// Writes every slot's card ID after reset/reload, then applies single-slot updates; keeps a readback shadow.
// Write pulse one cycle after a slot is scheduled, SETTLE_CYCLES hold after each; updates are refused while busy.
module slot_config_sequencer #(
  parameter int                            NUM_SLOTS     = 8,
  parameter logic [NUM_SLOTS-1:0][7:0]     SLOT_CARDS    = {8'd0, 8'd3, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1},
  parameter int                            SETTLE_CYCLES = 2
) (
  input  logic                         clk_logic,
  input  logic                         reset,
  input  logic [NUM_SLOTS-1:0]         slot_disable_i,
  input  logic                         reload_i,
  slot_config_sequencer_if.slave       cfg_bus,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot_i,
  output logic [7:0]                   rd_card_o
);

  localparam int                SLOT_W    = $clog2(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [3:0]        GAP_LAST  = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT_WR,
    INIT_GAP,
    IDLE,
    UPD_WR,
    UPD_GAP
  } state_t;

  state_t                      state_q, state_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [3:0]                  gap_q, gap_d;
  logic                        pending_q, pending_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        cfg_wr_q, cfg_wr_d;
  logic [SLOT_W-1:0]           cfg_slot_q, cfg_slot_d;
  logic [7:0]                  cfg_card_q, cfg_card_d;
  logic [SLOT_W-1:0]           upd_slot_q, upd_slot_d;
  logic [7:0]                  upd_card_q, upd_card_d;
  logic [NUM_SLOTS-1:0]        dis_q, dis_d;
  logic                        dis_vld_q, dis_vld_d;
  logic [NUM_SLOTS-1:0][7:0]   shadow_q, shadow_d;
  logic [7:0]                  rd_card_q, rd_card_d;

  logic       disable_changed;
  logic       reload_req;
  logic       gap_last;
  logic [7:0] wr_card;

  // The first sampled disable vector after reset is the baseline, not a change.
  assign disable_changed = dis_vld_q && (slot_disable_i != dis_q);
  assign reload_req      = reload_i || disable_changed;
  assign gap_last        = (gap_q == GAP_LAST);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    gap_d      = gap_q;
    pending_d  = pending_q;
    done_d     = done_q;
    cfg_wr_d   = 1'b0;
    cfg_slot_d = cfg_slot_q;
    cfg_card_d = cfg_card_q;
    upd_slot_d = upd_slot_q;
    upd_card_d = upd_card_q;
    shadow_d   = shadow_q;
    wr_card    = '0;

    case (state_q)
      INIT_WR: begin
        wr_card          = slot_disable_i[slot_q] ? 8'd0 : SLOT_CARDS[slot_q];
        cfg_wr_d         = 1'b1;
        cfg_slot_d       = slot_q;
        cfg_card_d       = wr_card;
        shadow_d[slot_q] = wr_card;
        gap_d            = '0;
        pending_d        = pending_q || reload_req;
        state_d          = INIT_GAP;
      end

      INIT_GAP: begin
        pending_d = pending_q || reload_req;
        if (!gap_last) begin
          gap_d = gap_q + 4'd1;
        end else if (slot_q != LAST_SLOT) begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = INIT_WR;
        end else if (pending_q || reload_req) begin
          // A reload seen during init restarts only once the whole pass has finished.
          slot_d    = '0;
          pending_d = 1'b0;
          done_d    = 1'b0;
          state_d   = INIT_WR;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (pending_q || reload_req) begin
          slot_d    = '0;
          pending_d = 1'b0;
          done_d    = 1'b0;
          state_d   = INIT_WR;
        end else if (cfg_bus.upd_valid_i) begin
          upd_slot_d = cfg_bus.upd_slot_i;
          upd_card_d = cfg_bus.upd_card_i;
          state_d    = UPD_WR;
        end
      end

      UPD_WR: begin
        wr_card              = slot_disable_i[upd_slot_q] ? 8'd0 : upd_card_q;
        cfg_wr_d             = 1'b1;
        cfg_slot_d           = upd_slot_q;
        cfg_card_d           = wr_card;
        shadow_d[upd_slot_q] = wr_card;
        gap_d                = '0;
        pending_d            = pending_q || reload_req;
        state_d              = UPD_GAP;
      end

      UPD_GAP: begin
        pending_d = pending_q || reload_req;
        if (!gap_last) begin
          gap_d = gap_q + 4'd1;
        end else if (pending_q || reload_req) begin
          slot_d    = '0;
          pending_d = 1'b0;
          done_d    = 1'b0;
          state_d   = INIT_WR;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        slot_d  = '0;
        state_d = INIT_WR;
      end
    endcase

    busy_d    = (state_d != IDLE);
    dis_d     = slot_disable_i;
    dis_vld_d = 1'b1;
    rd_card_d = shadow_q[rd_slot_i];
  end

  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      state_q    <= INIT_WR;
      slot_q     <= '0;
      gap_q      <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_wr_q   <= 1'b0;
      cfg_slot_q <= '0;
      cfg_card_q <= '0;
      upd_slot_q <= '0;
      upd_card_q <= '0;
      dis_q      <= '0;
      dis_vld_q  <= 1'b0;
      shadow_q   <= '0;
      rd_card_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_slot_q <= cfg_slot_d;
      cfg_card_q <= cfg_card_d;
      upd_slot_q <= upd_slot_d;
      upd_card_q <= upd_card_d;
      dis_q      <= dis_d;
      dis_vld_q  <= dis_vld_d;
      shadow_q   <= shadow_d;
      rd_card_q  <= rd_card_d;
    end
  end

  assign cfg_bus.upd_ready_o = (state_q == IDLE) && !pending_q && !reload_req;
  assign cfg_bus.cfg_wr_o    = cfg_wr_q;
  assign cfg_bus.cfg_slot_o  = cfg_slot_q;
  assign cfg_bus.cfg_card_o  = cfg_card_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign rd_card_o           = rd_card_q;

endmodule

// File: tb/tb_slot_config_sequencer.sv
// Bench for slot_config_sequencer: scoreboarded config write pulses (slot, card, cycle) plus
// table-driven runtime updates and hand-written reload/disable/reset corner sequences.
module tb_slot_config_sequencer;

  logic       clk_logic = 1'b0;
  logic       reset;
  logic [7:0] slot_disable_i;
  logic       reload_i;
  logic       busy_o;
  logic       done_o;
  logic [2:0] rd_slot_i;
  logic [7:0] rd_card_o;

  slot_config_sequencer_if bus ();

  slot_config_sequencer dut (
    .clk_logic      (clk_logic),
    .reset          (reset),
    .slot_disable_i (slot_disable_i),
    .reload_i       (reload_i),
    .cfg_bus        (bus),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rd_slot_i      (rd_slot_i),
    .rd_card_o      (rd_card_o)
  );

  always #5 clk_logic = ~clk_logic;

  int cyc = 0;
  always @(posedge clk_logic) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] slot;
    logic [7:0] card;
    int         cyc;
  } pulse_t;

  typedef struct {
    logic [7:0] dis;
    logic [2:0] slot;
    logic [7:0] card;
    logic [7:0] exp_card;
  } vec_t;

  pulse_t     exp_q[$];
  pulse_t     mon_p;
  logic [7:0] exp_shadow [8];
  logic [7:0] def_cards  [8] = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd3, 8'd0};
  vec_t       vecs [6];
  logic       prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every observed write pulse must match the oldest outstanding expectation.
  always @(negedge clk_logic) begin
    if (reset) begin
      prev_wr = 1'b0;
    end else begin
      if (bus.cfg_wr_o) begin
        chk("wr_back_to_back", prev_wr, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_slot", {29'd0, bus.cfg_slot_o}, 32'hffff_ffff);
        end else begin
          mon_p = exp_q.pop_front();
          chk("wr_slot", bus.cfg_slot_o, mon_p.slot);
          chk("wr_card", bus.cfg_card_o, mon_p.card);
          chk("wr_cycle", cyc, mon_p.cyc);
        end
      end
      prev_wr = bus.cfg_wr_o;
    end
  end

  task automatic push_init(input logic [7:0] dis, input int first);
    for (int k = 0; k < 8; k++) begin
      pulse_t p;
      p.slot = 3'(k);
      p.card = dis[k] ? 8'd0 : def_cards[k];
      p.cyc  = first + 3 * k;
      exp_q.push_back(p);
      exp_shadow[k] = p.card;
    end
  endtask

  task automatic reset_and_init(input logic [7:0] dis, input int reload_at);
    int r;
    int total;
    reset           = 1'b1;
    slot_disable_i  = dis;
    reload_i        = 1'b0;
    bus.upd_valid_i = 1'b0;
    rd_slot_i       = 3'd1;
    #1;
    chk("rst_wr",    bus.cfg_wr_o,    0);
    chk("rst_slot",  bus.cfg_slot_o,  0);
    chk("rst_card",  bus.cfg_card_o,  0);
    chk("rst_ready", bus.upd_ready_o, 0);
    chk("rst_busy",  busy_o,          0);
    chk("rst_done",  done_o,          0);
    chk("rst_rd",    rd_card_o,       0);
    repeat (3) @(posedge clk_logic);
    #1 reset = 1'b0;
    r     = cyc;
    total = (reload_at > 0) ? 48 : 24;
    push_init(dis, r + 1);
    if (reload_at > 0) push_init(dis, r + 25);
    for (int n = 1; n <= total; n++) begin
      @(posedge clk_logic);
      #1 reload_i = (n == reload_at);
      @(negedge clk_logic);
      chk("init_busy",  busy_o,          n < total);
      chk("init_done",  done_o,          n == total);
      chk("init_ready", bus.upd_ready_o, n == total);
      if (n == 1) chk("rd_shadow_cleared", rd_card_o, 0);
    end
    reload_i = 1'b0;
    @(posedge clk_logic);
    #1;
  endtask

  task automatic readback_all();
    for (int i = 0; i < 8; i++) begin
      rd_slot_i = 3'(i);
      @(posedge clk_logic);
      #1 chk("shadow_rd", rd_card_o, exp_shadow[i]);
    end
  endtask

  task automatic apply_dis(input logic [7:0] d);
    int c;
    slot_disable_i = d;
    c = cyc;
    push_init(d, c + 2);
    for (int n = 0; n <= 25; n++) begin
      @(negedge clk_logic);
      chk("dis_done", done_o, (n == 0) || (n == 25));
      if (n == 0) chk("dis_ready", bus.upd_ready_o, 0);
    end
    @(posedge clk_logic);
    #1;
  endtask

  task automatic do_update(input logic [2:0] s, input logic [7:0] c, input logic [7:0] ec,
                           input int max_wait, output int seen);
    pulse_t p;
    bit     ok;
    bus.upd_valid_i = 1'b1;
    bus.upd_slot_i  = s;
    bus.upd_card_i  = c;
    seen = -1;
    ok   = 1'b0;
    for (int w = 0; w <= max_wait && !ok; w++) begin
      @(negedge clk_logic);
      if (bus.upd_ready_o) begin
        ok     = 1'b1;
        seen   = cyc;
        p.slot = s;
        p.card = ec;
        p.cyc  = cyc + 2;
        exp_q.push_back(p);
        exp_shadow[s] = ec;
      end
    end
    chk("upd_accepted", ok, 1'b1);
    @(posedge clk_logic);
    #1 bus.upd_valid_i = 1'b0;
    if (ok) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk_logic);
        chk("upd_busy", busy_o, k <= 3);
      end
    end
    @(posedge clk_logic);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         seen;
    int         c;
    logic [7:0] cur_dis;

    reset           = 1'b0;
    slot_disable_i  = 8'h00;
    reload_i        = 1'b0;
    rd_slot_i       = 3'd0;
    bus.upd_valid_i = 1'b0;
    bus.upd_slot_i  = 3'd0;
    bus.upd_card_i  = 8'd0;

    vecs[0] = '{8'h00, 3'd5, 8'd2,  8'd2};
    vecs[1] = '{8'h00, 3'd0, 8'hff, 8'hff};
    vecs[2] = '{8'h00, 3'd7, 8'h80, 8'h80};
    vecs[3] = '{8'h20, 3'd5, 8'h09, 8'h00};
    vecs[4] = '{8'h20, 3'd4, 8'h5a, 8'h5a};
    vecs[5] = '{8'h00, 3'd5, 8'h11, 8'h11};
    #2;

    // Power-up init with defaults, then with slot 3 disabled from reset.
    reset_and_init(8'h00, 0);
    readback_all();
    reset_and_init(8'h08, 0);
    readback_all();

    // Runtime updates, some against a disabled slot.
    reset_and_init(8'h00, 0);
    cur_dis = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].dis != cur_dis) begin
        apply_dis(vecs[i].dis);
        cur_dis = vecs[i].dis;
      end
      do_update(vecs[i].slot, vecs[i].card, vecs[i].exp_card, 10, seen);
      rd_slot_i = vecs[i].slot;
      @(posedge clk_logic);
      #1 chk("upd_rd", rd_card_o, vecs[i].exp_card);
    end
    readback_all();

    // Reload during the gap after slot 4: init finishes, then a fresh pass runs.
    reset_and_init(8'h00, 13);
    readback_all();

    // Disable change in IDLE with an update held across the resulting reinit.
    slot_disable_i = 8'h40;
    c = cyc;
    push_init(8'h40, c + 2);
    do_update(3'd2, 8'd7, 8'd7, 60, seen);
    chk("held_upd_accept_cycle", seen, c + 25);
    readback_all();

    // Reset asserted in the middle of an update's settle gap.
    bus.upd_valid_i = 1'b1;
    bus.upd_slot_i  = 3'd1;
    bus.upd_card_i  = 8'h33;
    @(negedge clk_logic);
    chk("gap_rst_ready", bus.upd_ready_o, 1);
    exp_q.push_back('{3'd1, 8'h33, cyc + 2});
    @(posedge clk_logic);
    #1 bus.upd_valid_i = 1'b0;
    @(posedge clk_logic);
    @(negedge clk_logic);
    #2;
    reset_and_init(8'h00, 0);
    readback_all();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
